db_event_counter: RTL
=====================

// Module: db_event_counter
// PURPOSE
//  Downstream consumer of the debounced button level (db) and its sample tick (load).
//  - Turns each clean press into one count event.
//  - Long presses auto-repeat.
//  - Keeps a DIGITS-wide BCD up/down counter that feeds the 7-segment loader.
//  - Sits between the debouncer and the segment display mux.
// PARAMETERS
//  DIGITS        4   number of BCD decades in the counter (1..8)
//  HOLD_TICKS    50  load ticks db must stay high after the press before auto-repeat starts (>=2)
//  REPEAT_TICKS  10  load ticks between auto-repeat events (>=1)
// PORTS
//  clk       in   1          system clock; all state on posedge
//  rst       in   1          asynchronous, active-low reset
//  load      in   1          sample tick, one clk wide (same tick that drives the debouncer)
//  db        in   1          debounced button level; only sampled when load=1
//  up_dn     in   1          1 = count up, 0 = count down (sampled with each event)
//  clr       in   1          synchronous clear of the counter to 0
//  seg_load  in   1          synchronous parallel load of load_val
//  load_val  in   4*DIGITS   BCD preset; digit i = bits [4i+3:4i]
//  bcd       out  4*DIGITS   current BCD count
//  press     out  1          1-clk pulse per count event (press or repeat)
//  wrap      out  1          1-clk pulse when the counter wraps (99..9->0 up, 0->99..9 down)
//  state_o   out  2          current FSM state, for debug/LED
// BEHAVIOUR
//  Reset (rst=0, async): bcd=0, press=0, wrap=0, FSM=IDLE, tick counter=0.
//  db, up_dn, clr and seg_load are all sampled on clk. FSM and tick counter advance only on cycles with load=1.
//  FSM (encoding 0..2):
//   IDLE   : on load & db          -> HELD, event, tcnt=0
//   HELD   : on load & !db         -> IDLE
//            on load & db          -> tcnt++; if tcnt==HOLD_TICKS-1 -> REPEAT, event, tcnt=0
//   REPEAT : on load & !db         -> IDLE
//            on load & db          -> tcnt++; if tcnt==REPEAT_TICKS-1 -> event, tcnt=0
//   Entering IDLE clears tcnt.
//  Event: bcd updates on the same clk edge at which the event condition is sampled (latency 1 clk).
//   press is registered on that same edge and is high for exactly 1 clk.
//  Count arithmetic: per-decade BCD with ripple carry (up) or borrow (down).
//   - Up: 9 -> 0 with carry.
//   - Down: 0 -> 9 with borrow.
//   - Carry or borrow out of the top decade sets wrap for 1 clk, coincident with press.
//  Priority on a single edge: clr > seg_load > event.
//   - A blocked event still advances the FSM, but press=0 and wrap=0.
//   - clr and seg_load never pulse wrap.
//  seg_load: any digit of load_val >9 is loaded as 9.
//  load=0 cycles: the FSM is frozen. clr and seg_load still act.
//  db is only looked at when load=1. Glitches between ticks are ignored.
//  Reset mid-press: returns to IDLE. If db is still 1 at the first tick after reset, that counts as a new press.
// STRUCTURE
//  Shared package (db_pkg):
//   - state encoding localparams IDLE=2'd0, HELD=2'd1, REPEAT=2'd2
//   - BCD_W=4, BCD_MAX=4'd9
//  Sub-module bcd_digit: one decade; inputs en, up_dn, ld, ld_val, clr; outputs q, co (carry/borrow).
//   Instantiated DIGITS times in a generate loop, with co chained to the next decade's en.
//  Top level holds the FSM, tick counter ($clog2 of max(HOLD_TICKS,REPEAT_TICKS) bits), and press/wrap registers.
// TESTING (DIGITS=4, HOLD_TICKS=5, REPEAT_TICKS=2, load every 4 clk)
//  1 Reset: hold rst=0 with db=1 -> bcd=0000, press=0, state_o=0; release -> first tick gives press, bcd=0001.
//  2 Short press, up: db=1 for 3 ticks, then 0 -> exactly one press, bcd 0000->0001, state returns to IDLE.
//  3 Long press, up: db=1 for 12 ticks -> press at tick 1, 6, 8, 10, 12 (5 events); bcd=0005.
//  4 Wrap up: seg_load with load_val=9999, then one press up -> bcd=0000, wrap=1 for 1 clk, coincident with press.
//    Wrap down: from 0000 -> 9999, wrap=1.
//  5 Priority: clr and seg_load(0123) on the same clk as an event -> bcd=0000, press=0.
//    seg_load(0123) alone -> 0123. load_val=0x0A3F -> 0939.
//  6 Glitch: toggle db between ticks (load=0) -> no press, state stays IDLE.
//    Async reset asserted mid-REPEAT -> outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/db_pkg.sv
// Shared definitions for the button event counter: FSM state codes and BCD digit limits.
package db_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HELD   = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = IDLE,
        S_HELD   = HELD,
        S_REPEAT = REPEAT
    } state_t;

    // Presets above 9 are not valid BCD; they are held at 9.
    function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/db_event_counter_bcd_digit.sv
// One BCD decade with clear, preset and up/down step; co flags carry (up) or borrow (down).
module bcd_digit
    import db_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_val,
    input  logic             clr,
    output logic [BCD_W-1:0] q,
    output logic             co
);

    logic [BCD_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= bcd_sat(ld_val);
        end else if (en) begin
            if (up_dn) r_q <= (r_q == BCD_MAX) ? '0 : r_q + 1'b1;
            else       r_q <= (r_q == '0) ? BCD_MAX : r_q - 1'b1;
        end
    end

    assign co = en & (up_dn ? (r_q == BCD_MAX) : (r_q == '0));
    assign q  = r_q;

endmodule

// File: rtl/db_event_counter.sv
// Press/auto-repeat event generator driving a ripple BCD up/down counter for the 7-segment loader.
//
// state  | meaning
// IDLE   | button released, waiting for db high on a load tick
// HELD   | pressed, counting load ticks until auto-repeat starts
// REPEAT | auto-repeating, one event every REPEAT_TICKS load ticks
module db_event_counter
    import db_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int HOLD_TICKS   = 50,
    parameter int REPEAT_TICKS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  db,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  seg_load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic                  press,
    output logic                  wrap,
    output logic [1:0]            state_o
);

    localparam int TMAX   = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int TCNT_W = $clog2(TMAX);
    localparam logic [TCNT_W-1:0] HOLD_LAST = TCNT_W'(HOLD_TICKS - 1);
    localparam logic [TCNT_W-1:0] REP_LAST  = TCNT_W'(REPEAT_TICKS - 1);

    state_t              r_state, w_state_nxt;
    logic [TCNT_W-1:0]   r_tcnt, w_tcnt_nxt;
    logic                w_event;
    logic                w_cnt_en;
    logic [DIGITS:0]     w_en;
    logic                r_press;
    logic                r_wrap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_tcnt  <= '0;
            r_press <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_press <= w_cnt_en;
            r_wrap  <= w_en[DIGITS];
        end
    end

    // Terminal-count compare uses the pre-increment value, so the first
    // repeat lands HOLD_TICKS ticks after the initial press.
    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        w_event     = 1'b0;
        if (load) begin
            case (r_state)
                S_IDLE: begin
                    w_tcnt_nxt = '0;
                    if (db) begin
                        w_state_nxt = S_HELD;
                        w_event     = 1'b1;
                    end
                end
                S_HELD: begin
                    if (!db) begin
                        w_state_nxt = S_IDLE;
                        w_tcnt_nxt  = '0;
                    end else if (r_tcnt == HOLD_LAST) begin
                        w_state_nxt = S_REPEAT;
                        w_event     = 1'b1;
                        w_tcnt_nxt  = '0;
                    end else begin
                        w_tcnt_nxt = r_tcnt + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (!db) begin
                        w_state_nxt = S_IDLE;
                        w_tcnt_nxt  = '0;
                    end else if (r_tcnt == REP_LAST) begin
                        w_event    = 1'b1;
                        w_tcnt_nxt = '0;
                    end else begin
                        w_tcnt_nxt = r_tcnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_tcnt_nxt  = '0;
                end
            endcase
        end
    end

    // clr and seg_load suppress the count step but not the FSM advance.
    assign w_cnt_en = w_event & ~clr & ~seg_load;
    assign w_en[0]  = w_cnt_en;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .rst    (rst),
            .en     (w_en[i]),
            .up_dn  (up_dn),
            .ld     (seg_load),
            .ld_val (load_val[BCD_W*i +: BCD_W]),
            .clr    (clr),
            .q      (bcd[BCD_W*i +: BCD_W]),
            .co     (w_en[i+1])
        );
    end

    assign press   = r_press;
    assign wrap    = r_wrap;
    assign state_o = r_state;

endmodule
